seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-segment encoder. Samples a multiplexed, active-low 7-segment scan bus (segment lines plus one-hot digit strobe) and recovers, per digit position, the displayed hex nibble. A per-digit stability filter commits a digit only after repeated identical samples. Decode errors and blank digits are flagged. Sits in the display self-check / board-loopback path next to the PWM LED display logic.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_scan_decoder.sv | 107 ++++++++++
 tb/tb_seg7_scan_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bits 6..0 = g,f,e,d,c,b,a) for the
// encoder, the scan decoder and their benches.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: classifies a pattern
// as a hex digit, blank, or neither.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-segment scan
// bus, committing a digit only after STABLE_CNT identical accepted samples.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_en,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     code_err,
  output logic                  update,
  output logic [2:0]            update_idx,
  output logic                  scan_err
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  seg_t          cand [DIGITS];
  logic [CW-1:0] cnt  [DIGITS];

  logic          onehot;
  logic          accept;
  logic [IW-1:0] sel_idx;
  logic          match;
  logic          saturated;
  logic [CW-1:0] next_cnt;
  logic          commit;
  nibble_t       dec_nibble;
  logic          dec_is_hex;
  logic          dec_is_blank;

  seg7_pattern_decode u_decode (
    .seg      (seg_in),
    .nibble   (dec_nibble),
    .is_hex   (dec_is_hex),
    .is_blank (dec_is_blank)
  );

  // Select the strobed digit and run its stability filter.
  always_comb begin
    onehot  = $onehot(dig_sel);
    accept  = sample_en && onehot;
    sel_idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = IW'(i);
    end
    match     = (seg_in == cand[sel_idx]);
    saturated = (cnt[sel_idx] == CNT_MAX);
    if (!match)         next_cnt = CW'(1);
    else if (saturated) next_cnt = CNT_MAX;
    else                next_cnt = cnt[sel_idx] + CW'(1);
    // A saturated digit seeing the same pattern again must not re-commit.
    commit = accept && (next_cnt == CNT_MAX) && !(match && saturated);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        cand[k] <= SEG_BLANK;
        cnt[k]  <= '0;
      end
      digits      <= '0;
      digit_valid <= '0;
      blank       <= '0;
      code_err    <= '0;
      update      <= 1'b0;
      update_idx  <= 3'd0;
      scan_err    <= 1'b0;
    end else begin
      update   <= commit;
      scan_err <= sample_en && !onehot;
      if (commit) update_idx <= 3'(sel_idx);
      if (accept) begin
        cand[sel_idx] <= seg_in;
        cnt[sel_idx]  <= next_cnt;
      end
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (commit && (sel_idx == IW'(k))) begin
          if (dec_is_hex) begin
            digits[4*k +: 4] <= dec_nibble;
            digit_valid[k]   <= 1'b1;
            blank[k]         <= 1'b0;
            code_err[k]      <= 1'b0;
          end else if (dec_is_blank) begin
            digit_valid[k]   <= 1'b0;
            blank[k]         <= 1'b1;
            code_err[k]      <= 1'b0;
          end else begin
            digit_valid[k]   <= 1'b0;
            blank[k]         <= 1'b0;
            code_err[k]      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a STABLE_CNT=3 instance checked via a
// per-cycle scoreboard, plus a STABLE_CNT=1 instance on the same bus.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_en;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;

  logic [15:0] digits,  d1_digits;
  logic [3:0]  digit_valid, d1_digit_valid;
  logic [3:0]  blank, d1_blank;
  logic [3:0]  code_err, d1_code_err;
  logic        update, d1_update;
  logic [2:0]  update_idx, d1_update_idx;
  logic        scan_err, d1_scan_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       upd;
    logic [2:0] idx;
    logic       serr;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(3)) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .seg_in(seg_in),
    .dig_sel(dig_sel), .digits(digits), .digit_valid(digit_valid),
    .blank(blank), .code_err(code_err), .update(update),
    .update_idx(update_idx), .scan_err(scan_err)
  );

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .seg_in(seg_in),
    .dig_sel(dig_sel), .digits(d1_digits), .digit_valid(d1_digit_valid),
    .blank(d1_blank), .code_err(d1_code_err), .update(d1_update),
    .update_idx(d1_update_idx), .scan_err(d1_scan_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one sample, queue its expected pulses, compare after the edge.
  task automatic cyc(input logic en, input logic [3:0] sel, input logic [6:0] seg,
                     input logic eu, input logic [2:0] ei, input logic es,
                     input string tag);
    exp_t e;
    sample_en = en;
    dig_sel   = sel;
    seg_in    = seg;
    sb.push_back('{upd: eu, idx: ei, serr: es, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".update"}, 32'(update), 32'(e.upd));
    if (e.upd) chk({e.tag, ".update_idx"}, 32'(update_idx), 32'(e.idx));
    chk({e.tag, ".scan_err"}, 32'(scan_err), 32'(e.serr));
    @(negedge clk);
  endtask

  task automatic state(input string tag, input logic [15:0] ed, input logic [3:0] ev,
                       input logic [3:0] eb, input logic [3:0] ec);
    chk({tag, ".digits"}, 32'(digits), 32'(ed));
    chk({tag, ".digit_valid"}, 32'(digit_valid), 32'(ev));
    chk({tag, ".blank"}, 32'(blank), 32'(eb));
    chk({tag, ".code_err"}, 32'(code_err), 32'(ec));
  endtask

  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    sample_en = 1'b0;
    dig_sel   = 4'b0000;
    seg_in    = SEG_BLANK;
    repeat (n) @(posedge clk);
    #1;
    chk("rst.update", 32'(update), 32'd0);
    chk("rst.update_idx", 32'(update_idx), 32'd0);
    chk("rst.scan_err", 32'(scan_err), 32'd0);
    state("rst", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    seg_t rr[4];
    rr[0] = SEG_0; rr[1] = SEG_A; rr[2] = SEG_B; rr[3] = SEG_F;

    @(negedge clk);
    do_reset(2);
    chk("rst.d1_digits", 32'(d1_digits), 32'd0);
    chk("rst.d1_update", 32'(d1_update), 32'd0);

    // Digit 0 shows "2" three times.
    cyc(1'b1, 4'b0001, SEG_2, 1'b0, 3'd0, 1'b0, "d0_s1");
    cyc(1'b1, 4'b0001, SEG_2, 1'b0, 3'd0, 1'b0, "d0_s2");
    cyc(1'b1, 4'b0001, SEG_2, 1'b1, 3'd0, 1'b0, "d0_s3");
    state("d0", 16'h0002, 4'b0001, 4'b0000, 4'b0000);

    // Digit 1: a change mid-filter restarts the count.
    cyc(1'b1, 4'b0010, SEG_3, 1'b0, 3'd0, 1'b0, "d1_3a");
    cyc(1'b1, 4'b0010, SEG_3, 1'b0, 3'd0, 1'b0, "d1_3b");
    cyc(1'b1, 4'b0010, SEG_4, 1'b0, 3'd0, 1'b0, "d1_4a");
    cyc(1'b1, 4'b0010, SEG_4, 1'b0, 3'd0, 1'b0, "d1_4b");
    cyc(1'b1, 4'b0010, SEG_4, 1'b1, 3'd1, 1'b0, "d1_4c");
    state("d1", 16'h0042, 4'b0011, 4'b0000, 4'b0000);

    // Round-robin 0,A,b,F.
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        cyc(1'b1, 4'(1 << d), rr[d], (r == 2), 3'(d), 1'b0, $sformatf("rr%0d_%0d", r, d));
      end
    end
    state("rr", 16'hFBA0, 4'b1111, 4'b0000, 4'b0000);

    // Digit 2: 7, then blank, then an illegal pattern.
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, SEG_7, (i == 2), 3'd2, 1'b0, "d2_7");
    state("d2_7", 16'hF7A0, 4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, SEG_BLANK, (i == 2), 3'd2, 1'b0, "d2_blank");
    state("d2_blank", 16'hF7A0, 4'b1011, 4'b0100, 4'b0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, 7'b1010101, (i == 2), 3'd2, 1'b0, "d2_bad");
    state("d2_bad", 16'hF7A0, 4'b1011, 4'b0000, 4'b0100);

    // Scan errors and disabled samples leave a partial count on digit 3 intact.
    cyc(1'b1, 4'b1000, SEG_1, 1'b0, 3'd0, 1'b0, "d3_1a");
    cyc(1'b1, 4'b1000, SEG_1, 1'b0, 3'd0, 1'b0, "d3_1b");
    cyc(1'b1, 4'b0000, SEG_8, 1'b0, 3'd0, 1'b1, "serr_zero");
    cyc(1'b1, 4'b0110, SEG_8, 1'b0, 3'd0, 1'b1, "serr_multi");
    cyc(1'b0, 4'b0001, SEG_8, 1'b0, 3'd0, 1'b0, "en_low");
    state("serr", 16'hF7A0, 4'b1011, 4'b0000, 4'b0100);
    cyc(1'b1, 4'b1000, SEG_1, 1'b1, 3'd3, 1'b0, "d3_1c");
    state("d3", 16'h17A0, 4'b1011, 4'b0000, 4'b0100);

    // Reset mid-filter discards the partial count.
    cyc(1'b1, 4'b0001, SEG_8, 1'b0, 3'd0, 1'b0, "pre_rst_a");
    cyc(1'b1, 4'b0001, SEG_8, 1'b0, 3'd0, 1'b0, "pre_rst_b");
    do_reset(1);
    cyc(1'b1, 4'b0001, SEG_8, 1'b0, 3'd0, 1'b0, "post_rst_a");
    cyc(1'b1, 4'b0001, SEG_8, 1'b0, 3'd0, 1'b0, "post_rst_b");
    cyc(1'b1, 4'b0001, SEG_8, 1'b1, 3'd0, 1'b0, "post_rst_c");
    state("post_rst", 16'h0008, 4'b0001, 4'b0000, 4'b0000);

    // STABLE_CNT=1 instance commits every changed pattern on its first sample.
    cyc(1'b1, 4'b0001, SEG_5, 1'b0, 3'd0, 1'b0, "s1_5a");
    chk("s1_5a.d1_update", 32'(d1_update), 32'd1);
    chk("s1_5a.d1_idx", 32'(d1_update_idx), 32'd0);
    chk("s1_5a.d1_digit0", 32'(d1_digits[3:0]), 32'h5);
    chk("s1_5a.d1_valid", 32'(d1_digit_valid), 32'b0001);
    cyc(1'b1, 4'b0001, SEG_5, 1'b0, 3'd0, 1'b0, "s1_5b");
    chk("s1_5b.d1_update", 32'(d1_update), 32'd0);
    cyc(1'b1, 4'b0001, SEG_6, 1'b0, 3'd0, 1'b0, "s1_6");
    chk("s1_6.d1_update", 32'(d1_update), 32'd1);
    chk("s1_6.d1_digit0", 32'(d1_digits[3:0]), 32'h6);
    cyc(1'b1, 4'b0001, SEG_BLANK, 1'b0, 3'd0, 1'b0, "s1_blank");
    chk("s1_blank.d1_update", 32'(d1_update), 32'd1);
    chk("s1_blank.d1_blank", 32'(d1_blank), 32'b0001);
    chk("s1_blank.d1_valid", 32'(d1_digit_valid), 32'b0000);
    chk("s1_blank.d1_digit0", 32'(d1_digits[3:0]), 32'h6);
    state("s3_after", 16'h0008, 4'b0001, 4'b0000, 4'b0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
